// File: rtl/ehgu_basic_pkg.sv
// Shared basic types for ehgu blocks.
package ehgu_basic_pkg;

    typedef enum logic [1:0] {
        EDGE_OFF  = 2'd0,
        EDGE_RISE = 2'd1,
        EDGE_FALL = 2'd2,
        EDGE_BOTH = 2'd3
    } edge_mode_e;

endpackage

// File: rtl/ehgu_config_pkg.sv
// Default build parameters for the ehgu edge capture unit.
package ehgu_config_pkg;

    localparam int unsigned EDGE_NUM_CH      = 8;
    localparam int unsigned EDGE_SYNC_STAGES = 2;
    localparam int unsigned EDGE_DEB_WIDTH   = 4;

endpackage

// File: rtl/ehgu_edge_chan.sv
// One edge capture channel: synchroniser, optional debounce (EHGU_EDGE_DEBOUNCE_EN),
// edge pulses and sticky/overflow status.
module ehgu_edge_chan
    import ehgu_basic_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEB_WIDTH   = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 din,
    input  edge_mode_e           mode,
    input  logic [DEB_WIDTH-1:0] deb_len,
    input  logic                 clr,
    output logic                 level,
    output logic                 redge,
    output logic                 fedge,
    output logic                 toggle,
    output logic                 sticky,
    output logic                 ovf
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   level_q, level_d;
    logic                   redge_q, fedge_q, toggle_q;
    logic                   sticky_q, sticky_d;
    logic                   ovf_q, ovf_d;
    logic                   q;

    assign s = sync_q[SYNC_STAGES-1];

`ifdef EHGU_EDGE_DEBOUNCE_EN
    logic [DEB_WIDTH-1:0] cnt_q, cnt_d;

    // >= rather than == so a lowered deb_len takes effect at once without wrapping.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (s != level_q) begin
            if (cnt_q >= deb_len) begin
                level_d = s;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_deb_len;
    assign unused_deb_len = ^deb_len;
    assign level_d        = s;
`endif

    always_comb begin
        q = 1'b0;
        unique case (mode)
            EDGE_RISE: q = redge_q;
            EDGE_FALL: q = fedge_q;
            EDGE_BOTH: q = toggle_q;
            default:   q = 1'b0;
        endcase
    end

    // A coincident event beats the clear so no event is lost; clear suppresses overflow.
    always_comb begin
        sticky_d = q | (sticky_q & ~clr);
        ovf_d    = ~clr & (ovf_q | (q & sticky_q));
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync_q   <= '0;
            level_q  <= 1'b0;
            redge_q  <= 1'b0;
            fedge_q  <= 1'b0;
            toggle_q <= 1'b0;
            sticky_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], din};
            level_q  <= level_d;
            redge_q  <= level_d & ~level_q;
            fedge_q  <= ~level_d & level_q;
            toggle_q <= level_d ^ level_q;
            sticky_q <= sticky_d;
            ovf_q    <= ovf_d;
        end
    end

    assign level  = level_q;
    assign redge  = redge_q;
    assign fedge  = fedge_q;
    assign toggle = toggle_q;
    assign sticky = sticky_q;
    assign ovf    = ovf_q;

endmodule

// File: rtl/ehgu_edge_capture.sv
// Multi-channel edge capture top; debounce counters are built only with
// EHGU_EDGE_DEBOUNCE_EN defined.
module ehgu_edge_capture
    import ehgu_config_pkg::*;
    import ehgu_basic_pkg::*;
#(
    parameter int unsigned NUM_CH      = EDGE_NUM_CH,
    parameter int unsigned SYNC_STAGES = EDGE_SYNC_STAGES,
    parameter int unsigned DEB_WIDTH   = EDGE_DEB_WIDTH
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [NUM_CH-1:0]     din,
    input  logic [2*NUM_CH-1:0]   mode,
    input  logic [DEB_WIDTH-1:0]  deb_len,
    input  logic [NUM_CH-1:0]     clr,
    output logic [NUM_CH-1:0]     level,
    output logic [NUM_CH-1:0]     redge,
    output logic [NUM_CH-1:0]     fedge,
    output logic [NUM_CH-1:0]     toggle,
    output logic [NUM_CH-1:0]     sticky,
    output logic [NUM_CH-1:0]     ovf,
    output logic                  irq
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        ehgu_edge_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEB_WIDTH   (DEB_WIDTH)
        ) u_chan (
            .clk     (clk),
            .rstn    (rstn),
            .din     (din[i]),
            .mode    (edge_mode_e'(mode[2*i +: 2])),
            .deb_len (deb_len),
            .clr     (clr[i]),
            .level   (level[i]),
            .redge   (redge[i]),
            .fedge   (fedge[i]),
            .toggle  (toggle[i]),
            .sticky  (sticky[i]),
            .ovf     (ovf[i])
        );
    end

    assign irq = |sticky;

endmodule

// File: doc/ehgu_edge_capture.md
# ehgu_edge_capture

Multi-channel, parametrised edge capture unit: each channel synchronises an asynchronous input, optionally debounces it, detects rising, falling and any edges, and latches qualifying events into sticky status bits with write-1-to-clear semantics and a combined interrupt. It sits between raw pad or peer-domain level signals and the ehgu control/status logic, and supersedes per-signal single-edge detection.

## Interface
- NUM_CH, 8, number of independent channels (1..32)
- SYNC_STAGES, 2, synchroniser flop count per channel (min 2)
- DEB_WIDTH, 4, width of debounce length and counter
- clk  in  1  clock
- rstn  in  1  reset; synchronous, active-low
- din  in  NUM_CH  asynchronous channel inputs
- mode  in  2*NUM_CH  per-channel event qualifier, bits [2i+1:2i]: 0 off, 1 rise, 2 fall, 3 both
- deb_len  in  DEB_WIDTH  debounce length D, shared by all channels
- clr  in  NUM_CH  write-1-to-clear strobe for sticky/ovf
- level  out  NUM_CH  filtered level
- redge  out  NUM_CH  1-cycle pulse, filtered 0->1
- fedge  out  NUM_CH  1-cycle pulse, filtered 1->0
- toggle  out  NUM_CH  1-cycle pulse on either edge (redge|fedge)
- sticky  out  NUM_CH  latched qualifying event
- ovf  out  NUM_CH  qualifying event while sticky already set
- irq  out  1  OR of all sticky bits

## Operation
- Sync: din[i] passes through SYNC_STAGES flops -> s[i].
- Debounce per channel, counter cnt (DEB_WIDTH): if s==level: cnt<=0. Else if cnt>=deb_len: level<=s, cnt<=0. Else cnt<=cnt+1. New value must persist D+1 consecutive cycles at s; a shorter excursion leaves level unchanged and resets cnt.
- Using >= makes a mid-run decrease of deb_len take effect immediately, with no wrap; the counter never exceeds 2^DEB_WIDTH-1.
- redge/fedge/toggle are registered and assert in the same cycle level first shows the new value, for exactly one cycle.
- Qualifying event q[i] = (mode rise & redge) | (mode fall & fedge) | (mode both & toggle); mode off gives q=0 but pulses still drive.
- sticky: set on q, cleared on clr. When q and clr coincide, set wins (no lost event).
- ovf: set when q and sticky=1 and clr=0 in the same cycle; cleared by clr; set-on-q-with-clr does not set ovf.
- Mode changes take effect the next cycle and do not alter already latched bits.
- irq = |sticky, driven from registers, no extra latency.

## Timing
- Reset: sync chain, cnt, level, redge, fedge, toggle, sticky, ovf all 0; irq 0. Applies on the first rising clk edge with rstn=0, including mid-operation. Any debounce in progress is discarded.
- din held high through reset release produces a redge after the normal latency, because level resets to 0.
- Latency from din change (stable before edge 0) to level/pulse: SYNC_STAGES+1+D edges; defaults with D=0: 3 edges.
- sticky/ovf update 1 cycle after the pulse; irq follows sticky in the same cycle.
- Minimum edge spacing observable per channel: D+1 cycles.

## Configuration
- EHGU_EDGE_DEBOUNCE_EN defined: debounce counters built as above.
- Not defined: no counters; level<=s every cycle, so the design behaves as D=0. deb_len is present but ignored. Latency is SYNC_STAGES+1.

## Structure
- ehgu_config_pkg: EDGE_NUM_CH, EDGE_SYNC_STAGES, EDGE_DEB_WIDTH defaults.
- ehgu_basic_pkg: typedef enum logic [1:0] edge_mode_e {EDGE_OFF, EDGE_RISE, EDGE_FALL, EDGE_BOTH}.
- Sub-module ehgu_edge_chan: one channel's sync, debounce, level, pulses, sticky and ovf. The top instantiates it with a generate loop and ORs irq.

## Test plan
- Reset, D=0, mode[0]=rise; din[0] 0->1 before edge 0 -> level[0]/redge[0] at edge 3; sticky[0] at edge 4; irq=1; clr[0] pulse -> sticky[0]=0 next cycle.
- D=3: din[1] glitch high for 3 cycles -> no level change, no pulses. Hold 4+ cycles -> redge[1] at 2+1+3=6 edges after the change.
- mode[2]=both: two edges with no clr -> first sets sticky, second sets ovf; clr in the second-event cycle -> sticky stays 1, ovf stays 0.
- mode[3]=off: edges on din[3] -> redge/fedge/toggle pulse, sticky[3]=0, irq unchanged.
- D=15 with cnt at 10, then deb_len changed to 4 -> level updates next cycle; cnt returns to 0 with no wrap.
- rstn low mid-debounce with sticky set -> all outputs 0 after one edge. din[5]=1 at release -> redge[5] after 3 edges. Macro undefined: D=7 still gives latency 3.
